// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
package reg_dump_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StLoad,
      StSend,
      StDone
   } state_e;

   localparam int unsigned DEF_DATA_W     = 32;
   localparam int unsigned BYTES_PER_WORD = DEF_DATA_W / 8;
   localparam logic [7:0]  HDR_BYTE       = 8'hA5;

   // Counter width that stays legal when a word is a single byte.
   function automatic int unsigned cnt_width(input int unsigned bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/reg_dump_word_serializer.sv
// Word serializer: snapshots one register word and emits it LSB byte first
// over a valid/ready handshake.
module reg_dump_word_serializer
   import reg_dump_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              active,
   input  logic              ready,
   output logic              valid,
   output logic [7:0]        data,
   output logic              last_byte,
   output logic              fire
);

   localparam int unsigned Bytes = DATA_W / 8;
   localparam int unsigned CntW  = cnt_width(Bytes);

   logic [DATA_W-1:0] shreg_q;
   logic [CntW-1:0]   byte_cnt_q;

   assign valid     = active;
   assign fire      = active & ready;
   assign data      = active ? shreg_q[7:0] : 8'h00;
   assign last_byte = (byte_cnt_q == CntW'(Bytes - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shreg_q    <= '0;
         byte_cnt_q <= '0;
      end else if (load) begin
         shreg_q    <= load_data;
         byte_cnt_q <= '0;
      end else if (fire) begin
         shreg_q    <= shreg_q >> 8;
         byte_cnt_q <= byte_cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/reg_dump.sv
// Register-file dump reader: walks FIRST_REG..LAST_REG and streams each word
// little-endian as bytes. Define REG_DUMP_HEADER_EN to prefix the stream with 0xA5.
module reg_dump
   import reg_dump_pkg::*;
#(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   state_e     state_q;
   logic       ser_load;
   logic       ser_active;
   logic       ser_valid;
   logic       ser_last;
   logic       ser_fire;
   logic [7:0] ser_data;

   assign ser_load   = (state_q == StLoad);
   assign ser_active = (state_q == StSend);

   reg_dump_word_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .clk       (clk),
      .rstn      (rstn),
      .load      (ser_load),
      .load_data (rf_data),
      .active    (ser_active),
      .ready     (tx_ready),
      .valid     (ser_valid),
      .data      (ser_data),
      .last_byte (ser_last),
      .fire      (ser_fire)
   );

`ifdef REG_DUMP_HEADER_EN
   logic hdr_active;
   logic hdr_fire;

   assign hdr_active = (state_q == StHdr);
   assign hdr_fire   = hdr_active & tx_ready;
   assign tx_valid   = ser_valid | hdr_active;
   assign tx_data    = hdr_active ? HDR_BYTE : ser_data;
`else
   assign tx_valid   = ser_valid;
   assign tx_data    = ser_data;
`endif

   // tx_valid decodes straight from state so reset drops it asynchronously.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         rf_addr <= ADDR_W'(FIRST_REG);
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  busy    <= 1'b1;
                  rf_addr <= ADDR_W'(FIRST_REG);
`ifdef REG_DUMP_HEADER_EN
                  state_q <= StHdr;
`else
                  state_q <= StLoad;
`endif
               end
            end
`ifdef REG_DUMP_HEADER_EN
            StHdr: begin
               if (hdr_fire) state_q <= StLoad;
            end
`endif
            StLoad: begin
               state_q <= StSend;
            end
            StSend: begin
               if (ser_fire && ser_last) begin
                  if (rf_addr == ADDR_W'(LAST_REG)) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     rf_addr <= rf_addr + ADDR_W'(1);
                     state_q <= StLoad;
                  end
               end
            end
            StDone: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/reg_dump.md
Name: reg_dump

Overview:
- Debug reader for the register file. On a start pulse it walks register addresses FIRST_REG..LAST_REG through one combinational read port.
- Each 32-bit word is serialized as 4 bytes, little-endian, onto a valid/ready byte stream that feeds the UART transmitter.
- Used to dump architectural state to the host after the core halts. It complements the LED view of x2.

Parameters:
- FIRST_REG, 0, first register address dumped.
- LAST_REG, 31, last register address dumped (inclusive); FIRST_REG <= LAST_REG < 2**ADDR_W.
- ADDR_W, 5, register address width.
- DATA_W, 32, register width; must be a multiple of 8.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  request a dump; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the last byte of the dump has been accepted.
- rf_addr  out  ADDR_W  register read address; drives a regfile read port (e.g. a1).
- rf_data  in  DATA_W  combinational read data for rf_addr; x0 reads 0.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready at posedge.

Behaviour:
- Reset (async, rstn=0): state IDLE; busy=0, done=0, tx_valid=0, tx_data=0, rf_addr=FIRST_REG. Byte counter and shift register are cleared.
- States:
  - IDLE: start=1 at edge -> LOAD; rf_addr <= FIRST_REG. busy=1 from this edge.
  - LOAD: at edge, shreg <= rf_data (snapshot of the word for rf_addr); byte_cnt <= 0 -> SEND.
  - SEND: tx_valid=1, tx_data=shreg[7:0].
    - On tx_valid & tx_ready: shreg >>= 8, byte_cnt++.
    - When the accepted byte is byte DATA_W/8-1: if rf_addr==LAST_REG -> DONE, else rf_addr++ -> LOAD.
  - DONE: done=1 for exactly one cycle; busy=0 after this edge -> IDLE.
- Latency:
  - tx_valid first rises 2 cycles after start is sampled.
  - Each register costs 1 LOAD cycle plus at least 4 SEND cycles.
  - Minimum dump length with the default parameters is 32*5 + 2 cycles.
- Handshake:
  - tx_valid is held and tx_data is stable until accepted.
  - tx_valid never drops without acceptance, except on reset.
  - tx_valid=0 in IDLE, LOAD and DONE.
- start while busy (LOAD/SEND/DONE) is ignored and not queued.
- start held high continuously: a new dump begins on the IDLE cycle right after DONE.
- tx_ready stuck at 0: block waits indefinitely in SEND; no timeout.
- rf_data changing during SEND has no effect; only the LOAD-cycle value is sent.
- rf_addr changes only on LOAD transitions and on reset. It is held constant through SEND.
- Reset mid-dump: tx_valid drops immediately (asynchronously). The partial word is discarded and the next dump restarts at FIRST_REG.
- FIRST_REG==LAST_REG: a single word is dumped, then DONE.

Optional Feature:
- Macro: REG_DUMP_HEADER_EN.
- Defined: a header state HDR sits between IDLE and the first LOAD. It sends byte 0xA5 with the same handshake rules, and tx_valid first rises 1 cycle after start.
- Total bytes = 4*N + 1.
- Undefined: no header; the stream consists of register bytes only.

Decomposition:
- Package reg_dump_pkg:
  - state enum (IDLE, HDR, LOAD, SEND, DONE);
  - BYTES_PER_WORD = DATA_W/8;
  - HDR_BYTE = 8'hA5.
- Sub-module word_serializer: holds shreg and byte_cnt, exposes load/valid/ready/last_byte. Its handshake rules are the SEND rules above.

Test Plan:
- Regfile preloaded x1=0x11223344, x2=0xDEADBEEF; tx_ready=1; start pulse -> bytes 00 00 00 00 44 33 22 11 EF BE AD DE ... 128 bytes total. done pulses once after byte 128; busy is high throughout.
- tx_ready toggled randomly (~50%) -> same 128-byte sequence; tx_data is stable while tx_valid & !tx_ready; no byte duplicated or lost.
- Start re-pulsed mid-dump at byte 40 -> ignored; exactly 128 bytes and one done pulse.
- rstn asserted at byte 70 with tx_valid=1 -> tx_valid=0 before the next edge; after release and start, the dump restarts from x0 byte 0.
- FIRST_REG=LAST_REG=2, x2=0x0000BEEF -> bytes EF BE 00 00, then done; with REG_DUMP_HEADER_EN -> A5 EF BE 00 00.
